// File: rtl/tx_driver_pkg.sv
// Shared types and default message contents for the UART message sequencer.
package tx_driver_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SEND = 2'b01,
      WAIT = 2'b10,
      DONE = 2'b11
   } state_t;

   localparam int unsigned DEFAULT_MSG_LEN = 8;

   // "HELLO!\r\n"
   localparam logic [7:0] DEFAULT_MSG [DEFAULT_MSG_LEN] = '{
      8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h21, 8'h0D, 8'h0A
   };

endpackage

// File: rtl/tx_msg_rom.sv
// Combinational message ROM: byte index in, message byte out.
module tx_msg_rom
   import tx_driver_pkg::*;
#(
   parameter int unsigned MSG_LEN = 8,
   parameter int unsigned IDX_W   = 3
) (
   input  logic [IDX_W-1:0] idx,
   output logic [7:0]       msgByte
);

   // Messages longer than the default table repeat its contents.
   always_comb begin
      msgByte = '0;
      for (int unsigned i = 0; i < MSG_LEN; i++) begin
         if (idx == IDX_W'(i)) begin
            msgByte = DEFAULT_MSG[i % DEFAULT_MSG_LEN];
         end
      end
   end

endmodule

// File: rtl/tx_driver.sv
// Message sequencer feeding a UART transmitter one byte per XMitGo strobe.
module tx_driver
   import tx_driver_pkg::*;
#(
   parameter int unsigned MSG_LEN     = 8,
   parameter int unsigned REPEAT      = 1,
   parameter int unsigned ACK_TIMEOUT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       TxEmpty,
   output logic [7:0] TxData,
   output logic       XMitGo,
   output logic [1:0] OutState
);

   localparam int unsigned IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
   localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ACK_TIMEOUT - 1);

   state_t           state, stateNext;
   logic [IDX_W-1:0] idx, idxNext;
   logic [CNT_W-1:0] cnt, cntNext;
   logic [7:0]       dataNext;
   logic             goNext;
   logic [7:0]       romByte;

   tx_msg_rom #(
      .MSG_LEN (MSG_LEN),
      .IDX_W   (IDX_W)
   ) u_rom (
      .idx     (idx),
      .msgByte (romByte)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         idx    <= '0;
         cnt    <= '0;
         TxData <= '0;
         XMitGo <= 1'b0;
      end else begin
         state  <= stateNext;
         idx    <= idxNext;
         cnt    <= cntNext;
         TxData <= dataNext;
         XMitGo <= goNext;
      end
   end

   always_comb begin
      stateNext = state;
      idxNext   = idx;
      cntNext   = cnt;
      dataNext  = TxData;
      goNext    = 1'b0;
      case (state)
         IDLE: begin
            if (TxEmpty) begin
               stateNext = SEND;
               dataNext  = romByte;
               goNext    = 1'b1;
            end
         end
         SEND: begin
            stateNext = WAIT;
            cntNext   = '0;
            idxNext   = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
         end
         WAIT: begin
            // idx already advanced in SEND, so zero here means the last byte just went out
            if (!TxEmpty || cnt == CNT_MAX) begin
               stateNext = (REPEAT == 0 && idx == '0) ? DONE : IDLE;
            end else begin
               cntNext = cnt + CNT_W'(1);
            end
         end
         DONE: stateNext = DONE;
         default: stateNext = IDLE;
      endcase
   end

   assign OutState = state;

endmodule

// File: tb/tb_tx_driver.sv
// Scoreboard bench for tx_driver: expected bytes queued at stimulus, checked on each strobe.
module tb_tx_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       TxEmpty = 1'b0;
   logic [7:0] TxData, TxData2;
   logic       XMitGo, XMitGo2;
   logic [1:0] OutState, OutState2;

   tx_driver #(
      .MSG_LEN     (8),
      .REPEAT      (1),
      .ACK_TIMEOUT (4)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .TxEmpty  (TxEmpty),
      .TxData   (TxData),
      .XMitGo   (XMitGo),
      .OutState (OutState)
   );

   tx_driver #(
      .MSG_LEN     (8),
      .REPEAT      (0),
      .ACK_TIMEOUT (4)
   ) u_dutNoRep (
      .clk      (clk),
      .rst      (rst),
      .TxEmpty  (TxEmpty),
      .TxData   (TxData2),
      .XMitGo   (XMitGo2),
      .OutState (OutState2)
   );

   always #5 clk = ~clk;

   logic [7:0] msg [8] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h21, 8'h0D, 8'h0A};

   logic [7:0] expQ [$];
   int nAssert = 0;
   int nFail   = 0;
   int cyc     = 0;
   int lastStrobe = -100;
   int stuckPrev  = -1;
   bit stuck      = 1'b0;
   int strobes2   = 0;
   int expIdx     = 0;

   task automatic chk(input string name, input int act, input int exp);
      nAssert++;
      if (act != exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Monitor for the REPEAT=1 instance
   always @(negedge clk) begin
      cyc++;
      if (XMitGo2) strobes2++;
      if (XMitGo) begin
         chk("strobe state", OutState, 2'b01);
         nAssert++;
         if (cyc - lastStrobe < 3) begin
            nFail++;
            $display("FAIL strobe spacing: got %0d cycles required >=3", cyc - lastStrobe);
         end
         lastStrobe = cyc;
         if (stuck) begin
            if (stuckPrev >= 0) chk("stuck period", cyc - stuckPrev, 6);
            stuckPrev = cyc;
         end
         if (expQ.size() == 0) begin
            nAssert++;
            nFail++;
            $display("FAIL unexpected strobe: TxData %0h with no byte expected", TxData);
         end else begin
            chk("TxData", TxData, expQ.pop_front());
         end
      end
   end

   task automatic pushNext();
      expQ.push_back(msg[expIdx]);
      expIdx = (expIdx + 1) % 8;
   endtask

   task automatic pulse();
      @(negedge clk);
      TxEmpty = 1'b1;
      pushNext();
      @(negedge clk);
      TxEmpty = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      bit found;
      // Reset with TxEmpty high: nothing may move
      rst = 1'b0;
      TxEmpty = 1'b1;
      #1;
      chk("reset OutState", OutState, 2'b00);
      chk("reset TxData", TxData, 8'h00);
      chk("reset XMitGo", XMitGo, 0);
      repeat (5) begin
         @(negedge clk);
         chk("XMitGo in reset", XMitGo, 0);
         chk("OutState in reset", OutState, 2'b00);
      end
      TxEmpty = 1'b0;
      rst = 1'b1;

      // First byte with explicit state walk
      @(negedge clk);
      TxEmpty = 1'b1;
      pushNext();
      @(negedge clk);
      chk("first OutState", OutState, 2'b01);
      chk("first XMitGo", XMitGo, 1);
      chk("first TxData", TxData, 8'h48);
      TxEmpty = 1'b0;
      @(negedge clk);
      chk("wait OutState", OutState, 2'b10);
      chk("wait XMitGo", XMitGo, 0);
      chk("wait TxData hold", TxData, 8'h48);
      @(negedge clk);
      chk("back to idle", OutState, 2'b00);

      // Rest of the message
      repeat (7) pulse();
      chk("norep OutState DONE", OutState2, 2'b11);
      chk("norep strobe count", strobes2, 8);
      chk("norep last byte", TxData2, 8'h0A);

      // Wrap on REPEAT=1, DONE holds on REPEAT=0
      pulse();
      chk("norep no 9th strobe", strobes2, 8);
      chk("wrap TxData hold", TxData, 8'h48);

      // TxEmpty stuck high for 96 clk: 16 strobes, 6 clk apart
      @(negedge clk);
      stuck = 1'b1;
      stuckPrev = -1;
      TxEmpty = 1'b1;
      repeat (16) pushNext();
      repeat (96) @(negedge clk);
      TxEmpty = 1'b0;
      stuck = 1'b0;
      repeat (6) @(negedge clk);
      chk("stuck queue drained", expQ.size(), 0);
      chk("norep still DONE", OutState2, 2'b11);
      chk("norep strobes after stuck", strobes2, 8);

      // Two more bytes, then a third held in WAIT and reset mid-message
      pulse();
      pulse();
      @(negedge clk);
      TxEmpty = 1'b1;
      pushNext();
      found = 1'b0;
      for (int i = 0; i < 5 && !found; i++) begin
         @(negedge clk);
         if (OutState == 2'b10) found = 1'b1;
      end
      chk("reached WAIT", found, 1);
      chk("byte3 TxData", TxData, 8'h4C);
      #1 rst = 1'b0;
      #1;
      chk("midrst OutState", OutState, 2'b00);
      chk("midrst TxData", TxData, 8'h00);
      chk("midrst XMitGo", XMitGo, 0);
      chk("midrst norep OutState", OutState2, 2'b00);
      @(negedge clk);
      TxEmpty = 1'b0;
      rst = 1'b1;
      expIdx = 0;
      pulse();
      chk("after reset TxData", TxData, 8'h48);
      chk("after reset norep TxData", TxData2, 8'h48);

      repeat (4) @(negedge clk);
      chk("queue drained", expQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
